camera_orbit_ctrl: RTL and testbench

Converts single-cycle user steering pulses into spherical camera parameters: azimuth phi, elevation theta and orbit radius mag. It sits directly upstream of the camera basis/position stage. Phi and theta are kept as integer angle indices, and mag as a clamped fixed-point value. On every accepted update it produces sin/cos of both angles from one shared quarter-wave ROM and emits a one-cycle-valid parameter set.

---
 rtl/camera_orbit_ctrl_if.sv | 38 +++
 rtl/camera_orbit_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_camera_orbit_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/camera_orbit_ctrl_if.sv
// camera_orbit_ctrl_if: steering pulses in, spherical camera
// parameters plus busy/valid strobes out.
interface camera_orbit_ctrl_if #(
    parameter int SINCOS_WIDTH = 16,
    parameter int POS_WIDTH    = 18
);
    logic phi_inc_in;
    logic phi_dec_in;
    logic theta_inc_in;
    logic theta_dec_in;
    logic zoom_in_in;
    logic zoom_out_in;
    logic busy_out;
    logic signed [SINCOS_WIDTH-1:0] sin_phi_out;
    logic signed [SINCOS_WIDTH-1:0] cos_phi_out;
    logic signed [SINCOS_WIDTH-1:0] sin_theta_out;
    logic signed [SINCOS_WIDTH-1:0] cos_theta_out;
    logic [POS_WIDTH-1:0] mag_out;
    logic valid_out;

    modport master (
        output phi_inc_in, phi_dec_in,
        output theta_inc_in, theta_dec_in,
        output zoom_in_in, zoom_out_in,
        input  busy_out, valid_out, mag_out,
        input  sin_phi_out, cos_phi_out,
        input  sin_theta_out, cos_theta_out
    );

    modport slave (
        input  phi_inc_in, phi_dec_in,
        input  theta_inc_in, theta_dec_in,
        input  zoom_in_in, zoom_out_in,
        output busy_out, valid_out, mag_out,
        output sin_phi_out, cos_phi_out,
        output sin_theta_out, cos_theta_out
    );
endinterface

// File: rtl/camera_orbit_ctrl.sv
// camera_orbit_ctrl: steps phi/theta/mag from user pulses and emits
// sin/cos of both angles from one shared quarter-wave ROM.
module camera_orbit_ctrl #(
    parameter int ANGLE_BITS   = 10,
    parameter int SINCOS_WIDTH = 16,
    parameter int FRAC         = 14,
    parameter int POS_WIDTH    = 18,
    parameter int PHI_INIT     = 0,
    parameter int THETA_INIT   = 256,
    parameter int THETA_MIN    = 16,
    parameter int THETA_MAX    = 496,
    parameter int MAG_INIT     = 32768,
    parameter int MAG_MIN      = 8192,
    parameter int MAG_MAX      = 65536,
    parameter int MAG_STEP     = 4096
) (
    input logic clk_in,
    input logic rst_n_in,
    camera_orbit_ctrl_if.slave bus
);
    localparam int Q    = 1 << (ANGLE_BITS - 2);
    localparam int HALF = 1 << (ANGLE_BITS - 1);
    localparam int IW   = ANGLE_BITS - 1;
    localparam longint PI40 = 64'sd3454217652358;

    typedef logic [ANGLE_BITS-1:0] ang_t;
    typedef logic signed [SINCOS_WIDTH-1:0] sc_t;
    typedef logic [POS_WIDTH-1:0] mag_t;
    typedef logic [POS_WIDTH:0] wide_t;
    typedef enum logic [2:0] {
        START, IDLE, RD_SP, RD_CP, RD_ST, RD_CT, EMIT
    } state_t;

    // round(sin(pi*k/HALF) * 2^FRAC), Taylor series in 2^-30 fixed point
    function automatic int qsin(input int k);
        longint x, x2, term, acc;
        x = (PI40 * longint'(k)) / longint'(HALF);
        x = x >>> 10;
        x2 = (x * x) >>> 30;
        term = x;
        acc = x;
        for (int n = 1; n < 10; n++) begin
            term = -((term * x2) >>> 30)
                   / longint'((2 * n) * (2 * n + 1));
            acc = acc + term;
        end
        return int'((acc + (64'sd1 <<< (29 - FRAC))) >>> (30 - FRAC));
    endfunction

    sc_t sin_tbl [0:Q];
    for (genvar k = 0; k <= Q; k++) begin : g_tbl
        localparam int V = qsin(k);
        assign sin_tbl[k] = sc_t'(V);
    end

    state_t state_q, state_d;
    ang_t phi_q, phi_d, theta_q, theta_d;
    mag_t mag_q, mag_d, mag_out_q, mag_out_d;
    sc_t hold_sp_q, hold_sp_d, hold_cp_q, hold_cp_d;
    sc_t hold_st_q, hold_st_d, hold_ct_q, hold_ct_d;
    sc_t sin_phi_q, sin_phi_d, cos_phi_q, cos_phi_d;
    sc_t sin_th_q, sin_th_d, cos_th_q, cos_th_d;
    logic valid_q, valid_d, busy_q, busy_d;

    ang_t rom_addr;
    logic [1:0] quad;
    logic [IW-1:0] rem, idx;
    sc_t rom_val;
    logic accept;
    wide_t mag_up, mag_dn;

    // ROM address per read state; cos(a) reads sin(a + Q)
    always_comb begin
        unique case (state_q)
            RD_CP:   rom_addr = phi_q + ang_t'(Q);
            RD_ST:   rom_addr = theta_q;
            RD_CT:   rom_addr = theta_q + ang_t'(Q);
            default: rom_addr = phi_q;
        endcase
        quad = rom_addr[ANGLE_BITS-1 -: 2];
        rem = {1'b0, rom_addr[ANGLE_BITS-3:0]};
        idx = quad[0] ? IW'(Q) - rem : rem;
        rom_val = quad[1] ? -sin_tbl[idx] : sin_tbl[idx];
    end

    // step rules, applied only on the edge a pulse is accepted
    always_comb begin
        accept = (state_q == IDLE) && !busy_q &&
                 (bus.phi_inc_in | bus.phi_dec_in |
                  bus.theta_inc_in | bus.theta_dec_in |
                  bus.zoom_in_in | bus.zoom_out_in);
        phi_d = phi_q;
        theta_d = theta_q;
        mag_d = mag_q;
        mag_up = {1'b0, mag_q} + wide_t'(MAG_STEP);
        mag_dn = {1'b0, mag_q} - wide_t'(MAG_STEP);
        if (mag_up > wide_t'(MAG_MAX))
            mag_up = wide_t'(MAG_MAX);
        if (mag_dn[POS_WIDTH] || mag_dn < wide_t'(MAG_MIN))
            mag_dn = wide_t'(MAG_MIN);
        if (accept) begin
            if (bus.phi_inc_in && !bus.phi_dec_in)
                phi_d = phi_q + ang_t'(1);
            else if (bus.phi_dec_in && !bus.phi_inc_in)
                phi_d = phi_q - ang_t'(1);
            if (bus.theta_inc_in && !bus.theta_dec_in)
                theta_d = (theta_q >= ang_t'(THETA_MAX)) ?
                          ang_t'(THETA_MAX) : theta_q + ang_t'(1);
            else if (bus.theta_dec_in && !bus.theta_inc_in)
                theta_d = (theta_q <= ang_t'(THETA_MIN)) ?
                          ang_t'(THETA_MIN) : theta_q - ang_t'(1);
            if (bus.zoom_in_in && !bus.zoom_out_in)
                mag_d = mag_up[POS_WIDTH-1:0];
            else if (bus.zoom_out_in && !bus.zoom_in_in)
                mag_d = mag_dn[POS_WIDTH-1:0];
        end
    end

    // sequencer: four ROM reads into holding regs, then one emit
    always_comb begin
        state_d = state_q;
        hold_sp_d = hold_sp_q;
        hold_cp_d = hold_cp_q;
        hold_st_d = hold_st_q;
        hold_ct_d = hold_ct_q;
        sin_phi_d = sin_phi_q;
        cos_phi_d = cos_phi_q;
        sin_th_d = sin_th_q;
        cos_th_d = cos_th_q;
        mag_out_d = mag_out_q;
        valid_d = 1'b0;
        unique case (state_q)
            START: state_d = RD_SP;
            IDLE:  if (accept) state_d = RD_SP;
            RD_SP: begin
                hold_sp_d = rom_val;
                state_d = RD_CP;
            end
            RD_CP: begin
                hold_cp_d = rom_val;
                state_d = RD_ST;
            end
            RD_ST: begin
                hold_st_d = rom_val;
                state_d = RD_CT;
            end
            RD_CT: begin
                hold_ct_d = rom_val;
                state_d = EMIT;
            end
            EMIT: begin
                sin_phi_d = hold_sp_q;
                cos_phi_d = hold_cp_q;
                sin_th_d = hold_st_q;
                cos_th_d = hold_ct_q;
                mag_out_d = mag_q;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // busy also covers the valid cycle so accepts are 7 apart
        busy_d = (state_d != IDLE) || valid_d;
    end

    // all state; reset reloads the initial camera pose
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= START;
            phi_q <= ang_t'(PHI_INIT);
            theta_q <= ang_t'(THETA_INIT);
            mag_q <= mag_t'(MAG_INIT);
            hold_sp_q <= '0;
            hold_cp_q <= '0;
            hold_st_q <= '0;
            hold_ct_q <= '0;
            sin_phi_q <= '0;
            cos_phi_q <= '0;
            sin_th_q <= '0;
            cos_th_q <= '0;
            mag_out_q <= '0;
            valid_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phi_q <= phi_d;
            theta_q <= theta_d;
            mag_q <= mag_d;
            hold_sp_q <= hold_sp_d;
            hold_cp_q <= hold_cp_d;
            hold_st_q <= hold_st_d;
            hold_ct_q <= hold_ct_d;
            sin_phi_q <= sin_phi_d;
            cos_phi_q <= cos_phi_d;
            sin_th_q <= sin_th_d;
            cos_th_q <= cos_th_d;
            mag_out_q <= mag_out_d;
            valid_q <= valid_d;
            busy_q <= busy_d;
        end
    end

    assign bus.sin_phi_out = sin_phi_q;
    assign bus.cos_phi_out = cos_phi_q;
    assign bus.sin_theta_out = sin_th_q;
    assign bus.cos_theta_out = cos_th_q;
    assign bus.mag_out = mag_out_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out = busy_q;
endmodule

// File: tb/tb_camera_orbit_ctrl.sv
// tb_camera_orbit_ctrl: directed steps with hand-computed sin/cos,
// clamp, drop and reset-abort expectations.
module tb_camera_orbit_ctrl;
    localparam logic [5:0] P_PHI_INC = 6'b100000;
    localparam logic [5:0] P_PHI_DEC = 6'b010000;
    localparam logic [5:0] P_TH_INC  = 6'b001000;
    localparam logic [5:0] P_TH_DEC  = 6'b000100;
    localparam logic [5:0] P_ZIN     = 6'b000010;
    localparam logic [5:0] P_ZOUT    = 6'b000001;

    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    int total = 0;
    int bad = 0;
    int vcount = 0;
    int v0;

    camera_orbit_ctrl_if #(.SINCOS_WIDTH(16), .POS_WIDTH(18)) bus ();

    camera_orbit_ctrl dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    // count every emitted parameter set
    always @(posedge clk_in) begin
        if (bus.valid_out) vcount <= vcount + 1;
    end

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic step(input logic [5:0] p);
        bus.phi_inc_in = p[5];
        bus.phi_dec_in = p[4];
        bus.theta_inc_in = p[3];
        bus.theta_dec_in = p[2];
        bus.zoom_in_in = p[1];
        bus.zoom_out_in = p[0];
        tick();
        bus.phi_inc_in = 1'b0;
        bus.phi_dec_in = 1'b0;
        bus.theta_inc_in = 1'b0;
        bus.theta_dec_in = 1'b0;
        bus.zoom_in_in = 1'b0;
        bus.zoom_out_in = 1'b0;
    endtask

    task automatic wait_emit(input string tag, input int lat,
                             input bit full,
                             input int sp, input int cp,
                             input int st, input int ct,
                             input int mg);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!bus.valid_out && c < 12);
        chk({tag, ":latency"}, c, lat);
        if (full) begin
            chk({tag, ":sin_phi"}, bus.sin_phi_out, sp);
            chk({tag, ":cos_phi"}, bus.cos_phi_out, cp);
            chk({tag, ":sin_theta"}, bus.sin_theta_out, st);
            chk({tag, ":cos_theta"}, bus.cos_theta_out, ct);
            chk({tag, ":mag"}, bus.mag_out, mg);
        end
        chk({tag, ":busy_emit"}, bus.busy_out, 1);
        tick();
        chk({tag, ":valid_drop"}, bus.valid_out, 0);
        chk({tag, ":busy_low"}, bus.busy_out, 0);
    endtask

    initial begin
        bus.phi_inc_in = 1'b0;
        bus.phi_dec_in = 1'b0;
        bus.theta_inc_in = 1'b0;
        bus.theta_dec_in = 1'b0;
        bus.zoom_in_in = 1'b0;
        bus.zoom_out_in = 1'b0;
        tick();
        tick();
        chk("rst:sin_phi", bus.sin_phi_out, 0);
        chk("rst:cos_phi", bus.cos_phi_out, 0);
        chk("rst:mag", bus.mag_out, 0);
        chk("rst:valid", bus.valid_out, 0);
        chk("rst:busy", bus.busy_out, 0);

        rst_n_in = 1'b1;
        tick();
        chk("init:busy", bus.busy_out, 1);
        wait_emit("init", 5, 1'b1, 0, 16384, 16384, 0, 32768);

        step(P_PHI_DEC);
        wait_emit("phi_wrap", 5, 1'b1, -101, 16384, 16384, 0, 32768);

        step(P_TH_INC);
        wait_emit("theta257", 5, 1'b1, -101, 16384, 16384, -101, 32768);

        for (int i = 0; i < 239; i++) begin
            step(P_TH_INC);
            wait_emit("theta_run", 5, 1'b0, 0, 0, 0, 0, 0);
        end
        step(P_TH_INC);
        wait_emit("theta_max", 5, 1'b1, -101, 16384, 1606, -16305, 32768);
        step(P_TH_INC);
        wait_emit("theta_sat", 5, 1'b1, -101, 16384, 1606, -16305, 32768);

        for (int i = 0; i < 8; i++) begin
            step(P_ZIN);
            wait_emit("zin_run", 5, 1'b0, 0, 0, 0, 0, 0);
        end
        step(P_ZIN);
        wait_emit("zin_sat", 5, 1'b1, -101, 16384, 1606, -16305, 65536);

        for (int i = 0; i < 13; i++) begin
            step(P_ZOUT);
            wait_emit("zout_run", 5, 1'b0, 0, 0, 0, 0, 0);
        end
        step(P_ZOUT);
        wait_emit("zout_min", 5, 1'b1, -101, 16384, 1606, -16305, 8192);
        step(P_ZOUT);
        wait_emit("zout_sat", 5, 1'b1, -101, 16384, 1606, -16305, 8192);

        v0 = vcount;
        step(P_PHI_INC | P_PHI_DEC | P_ZIN);
        tick();
        tick();
        step(P_TH_INC);
        wait_emit("combo", 2, 1'b1, -101, 16384, 1606, -16305, 12288);
        for (int i = 0; i < 8; i++) tick();
        chk("combo:one_valid", vcount - v0, 1);
        step(P_PHI_INC);
        wait_emit("dropped", 5, 1'b1, 0, 16384, 1606, -16305, 12288);

        step(P_TH_DEC);
        tick();
        tick();
        v0 = vcount;
        rst_n_in = 1'b0;
        #1;
        chk("abort:sin_phi", bus.sin_phi_out, 0);
        chk("abort:cos_phi", bus.cos_phi_out, 0);
        chk("abort:sin_theta", bus.sin_theta_out, 0);
        chk("abort:cos_theta", bus.cos_theta_out, 0);
        chk("abort:mag", bus.mag_out, 0);
        chk("abort:busy", bus.busy_out, 0);
        tick();
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        wait_emit("reinit", 5, 1'b1, 0, 16384, 16384, 0, 32768);
        chk("abort:valid_count", vcount - v0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
